// File: rtl/flash_pkg.sv
// Shared encodings for the sector-erasable flash model: op codes, FSM states
// and the erased bit value.
package flash_pkg;

  typedef enum logic [1:0] {
    OP_READ         = 2'd0,
    OP_PROG         = 2'd1,
    OP_ERASE_SECTOR = 2'd2,
    OP_ERASE_ALL    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROG  = 2'd1,
    ST_ERASE = 2'd2
  } state_e;

  // Value of every bit of an erased word; replicate to the word width.
  localparam logic ERASED_VALUE = 1'b0;

endpackage

// File: rtl/flash_mem.sv
// Non-volatile word array: combinational read, one synchronous write port,
// deliberately without reset.
module flash_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sector_flash.sv
// Flash controller: single-cycle reads, timed word program, sector/chip erase
// one word per cycle. Optional write protect via FLASH_WRITE_PROTECT_EN.
module sector_flash
  import flash_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 12,
  parameter int DEPTH        = 1024,
  parameter int SECTOR_WORDS = 64,
  parameter int PROG_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef FLASH_WRITE_PROTECT_EN
  ,
  input  logic              wp
`endif
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_MAX = (DEPTH > PROG_CYCLES) ? DEPTH : PROG_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] ERASED_WORD = {DATA_W{ERASED_VALUE}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] pdata_q, pdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  op_e  op_c;
  logic acc, out_of_range, not_erased, protect, reject;

  flash_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (ptr_q),
    .wdata (mem_wdata),
    .raddr (addr[IDX_W-1:0]),
    .rdata (mem_rdata)
  );

  assign op_c         = op_e'(op);
  assign req_ready    = (state_q == ST_IDLE) && !rst;
  assign acc          = req_valid && req_ready;
  assign out_of_range = (op_c != OP_ERASE_ALL) && ({1'b0, addr} >= DEPTH_L);
  // Programming can only clear-to-set bits, so a non-erased target is refused.
  assign not_erased   = (op_c == OP_PROG) && (mem_rdata != ERASED_WORD);

`ifdef FLASH_WRITE_PROTECT_EN
  localparam int SEC_SH = $clog2(SECTOR_WORDS);
  assign protect = wp && ((op_c == OP_ERASE_ALL) ||
                   (((op_c == OP_PROG) || (op_c == OP_ERASE_SECTOR)) &&
                    ((addr >> SEC_SH) == '0)));
`else
  assign protect = 1'b0;
`endif

  assign reject = out_of_range || not_erased || protect;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    pdata_d   = pdata_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = (state_q == ST_PROG) ? pdata_q : ERASED_WORD;

    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (reject) begin
            error_d = 1'b1;
          end else begin
            unique case (op_c)
              OP_READ: begin
                rdata_d  = mem_rdata;
                rvalid_d = 1'b1;
              end
              OP_PROG: begin
                state_d = ST_PROG;
                cnt_d   = CNT_W'(PROG_CYCLES - 1);
                ptr_d   = addr[IDX_W-1:0];
                pdata_d = wdata;
              end
              OP_ERASE_SECTOR: begin
                state_d = ST_ERASE;
                cnt_d   = CNT_W'(SECTOR_WORDS - 1);
                ptr_d   = addr[IDX_W-1:0] & ~IDX_W'(SECTOR_WORDS - 1);
              end
              default: begin
                state_d = ST_ERASE;
                cnt_d   = CNT_W'(DEPTH - 1);
                ptr_d   = '0;
              end
            endcase
          end
        end
      end
      ST_PROG, ST_ERASE: begin
        // Erase writes every busy cycle; program only on its final cycle.
        mem_we = (state_q == ST_ERASE) || (cnt_q == '0);
        if (state_q == ST_ERASE) ptr_d = ptr_q + IDX_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      pdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      pdata_q  <= pdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign done   = done_q;
  assign error  = error_q;

endmodule

// File: tb/tb_sector_flash.sv
// Scoreboard bench for sector_flash: read data queued at issue, popped on rvalid;
// busy/done/error timing checked directly against a bench-side memory model.
module tb_sector_flash;
  import flash_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1024;
  localparam int SW     = 64;
  localparam int PC     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic [1:0]        op = 2'd0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              req_ready, rvalid, busy, done, error;
  logic [DATA_W-1:0] rdata;
`ifdef FLASH_WRITE_PROTECT_EN
  logic              wp = 1'b0;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  sector_flash #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .SECTOR_WORDS(SW), .PROG_CYCLES(PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .busy      (busy),
    .done      (done),
    .error     (error)
`ifdef FLASH_WRITE_PROTECT_EN
    ,
    .wp        (wp)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (exp_q.size() == 0) chk("rvalid_unexpected", 64'd1, 64'd0);
      else chk("rdata", rdata, exp_q.pop_front());
    end
  end

  task automatic drive(input op_e o, input int a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; op = o; addr = ADDR_W'(a); wdata = d;
    if (o == OP_READ && a < DEPTH) exp_q.push_back(model[a]);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_busy(input string tag, input int exp_n);
    int n = 0;
    while (busy && n < 5000) begin
      n++;
      @(posedge clk); #1;
    end
    chk({tag, "_busy_cycles"}, n, exp_n);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_ready_with_done"}, req_ready, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic expect_reject(input string tag);
    chk({tag, "_error"}, error, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rvalid"}, rvalid, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_error_pulse"}, error, 1'b0);
  endtask

  task automatic prog(input int a, input logic [DATA_W-1:0] d);
    drive(OP_PROG, a, d);
    model[a] = d;
    wait_busy("prog", PC);
  endtask

  task automatic read_burst(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b1; op = OP_READ; addr = ADDR_W'(start + i);
      exp_q.push_back(model[start + i]);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("burst_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", req_ready, 1'b1);

    // Establish a known erased array
    drive(OP_ERASE_ALL, 0, '0);
    wait_busy("erase_all_init", DEPTH);

    // Program onto an erased word, then read it back
    prog(5, 32'hDEADBEEF);
    drive(OP_READ, 5, '0);
    chk("read5_rvalid", rvalid, 1'b1);
    @(posedge clk); #1;
    chk("read5_rvalid_pulse", rvalid, 1'b0);
    chk("rdata_hold", rdata, 32'hDEADBEEF);

    // Reprogramming a non-erased word is refused
    drive(OP_PROG, 5, 32'h12345678);
    expect_reject("prog_twice");
    drive(OP_READ, 5, '0);

    // Sector erase clears 64..127 only
    prog(64, 32'hA5A5_0064);
    prog(127, 32'hA5A5_0127);
    prog(128, 32'hA5A5_0128);
    drive(OP_ERASE_SECTOR, 70, '0);
    for (int i = 64; i < 128; i++) model[i] = '0;
    wait_busy("erase_sector", SW);
    read_burst(60, 72);

    // Out-of-range read, then full chip erase
    drive(OP_READ, 1024, '0);
    expect_reject("read_oor");
    prog(0, 32'h0000_0001);
    prog(1023, 32'h8000_0000);
    drive(OP_ERASE_ALL, 4000, '0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    wait_busy("erase_all", DEPTH);
    read_burst(0, DEPTH);

    // Reset part-way through a sector erase
    prog(64, 32'h1111_0064);
    prog(70, 32'h1111_0070);
    prog(73, 32'h1111_0073);
    prog(74, 32'h1111_0074);
    prog(100, 32'h1111_0100);
    prog(127, 32'h1111_0127);
    drive(OP_READ, 74, '0);
    drive(OP_ERASE_SECTOR, 65, '0);
    repeat (10) @(posedge clk);
    #1;
    chk("erase_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    for (int i = 64; i < 74; i++) model[i] = '0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", req_ready, 1'b0);
    chk("async_rst_rdata", rdata, 0);
    chk("async_rst_done", done, 1'b0);
    chk("async_rst_rvalid", rvalid, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    read_burst(64, 64);

`ifdef FLASH_WRITE_PROTECT_EN
    wp = 1'b1;
    drive(OP_PROG, 3, 32'hCAFE_0003);
    expect_reject("wp_prog");
    drive(OP_ERASE_ALL, 0, '0);
    expect_reject("wp_erase_all");
    drive(OP_READ, 3, '0);
    wp = 1'b0;
    prog(3, 32'hCAFE_0003);
    drive(OP_READ, 3, '0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sector_flash.md
SECTOR_FLASH -- requirements
Module: sector_flash

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width.
REQ-002 SHALL have parameter ADDR_W, default 12, address width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words (DEPTH <= 2**ADDR_W).
REQ-004 SHALL have parameter SECTOR_WORDS, default 64, words per erase sector (power of 2, divides DEPTH).
REQ-005 SHALL have parameter PROG_CYCLES, default 4, busy cycles per word program (>= 1).
REQ-006 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports: req_valid  in  1  request strobe; req_ready  out  1  request accepted when high with req_valid.
REQ-008 SHALL have ports: op  in  2  operation (READ=0, PROG=1, ERASE_SECTOR=2, ERASE_ALL=3); addr  in  ADDR_W  word address; wdata  in  DATA_W  program data.
REQ-009 SHALL have ports: rdata  out  DATA_W  read data; rvalid  out  1  read data valid pulse; busy  out  1  program/erase in progress; done  out  1  completion pulse; error  out  1  rejection pulse.

Function
REQ-010 SHALL implement states IDLE, PROG, ERASE; req_ready = 1 only in IDLE and not in reset.
REQ-011 SHALL accept a request on a rising clk edge with req_valid=1 and req_ready=1; requests while req_ready=0 are ignored, not queued.
REQ-012 SHALL treat the erased word value as all-zeros.
REQ-013 SHALL reject at acceptance, with no memory change and no state change: addr >= DEPTH for any op except ERASE_ALL, and PROG to a word not equal to zero.
REQ-014 SHALL on rejection drive error=1 for exactly the one cycle after the accepting edge, with busy, done and rvalid all 0.
REQ-015 SHALL on an accepted READ register rdata=mem[addr] and rvalid=1 for exactly one cycle, while staying in IDLE; back-to-back READs SHALL sustain one per cycle.
REQ-016 SHALL on an accepted PROG enter PROG and hold busy=1 for exactly PROG_CYCLES cycles, using a down-counter.
REQ-017 SHALL write wdata to mem[addr] on the last busy edge of PROG.
REQ-018 SHALL on an accepted ERASE_SECTOR clear words base..base+SECTOR_WORDS-1, one word per cycle, where base = addr with the low log2(SECTOR_WORDS) bits zeroed; busy SHALL be 1 for exactly SECTOR_WORDS cycles.
REQ-019 SHALL on an accepted ERASE_ALL ignore addr and clear words 0..DEPTH-1, one word per cycle, with busy=1 for exactly DEPTH cycles.
REQ-020 SHALL after PROG or ERASE return to IDLE and drive done=1 for the first IDLE cycle only; req_ready SHALL be 1 in that same cycle.
REQ-021 SHALL hold rdata at its last value when rvalid=0.

Reset
REQ-022 SHALL on rst=1 immediately force: state IDLE, busy=0, done=0, error=0, rvalid=0, rdata=0, counters=0; req_ready=0 while rst=1.
REQ-023 SHALL NOT reset memory contents (non-volatile).
REQ-024 SHALL on a reset during ERASE leave already-cleared words zero and the rest unchanged; on a reset during PROG, the word SHALL be unchanged unless the final write edge has already occurred.

Configuration
REQ-025 SHALL, when FLASH_WRITE_PROTECT_EN is defined, add input port wp (1 bit, after error).
REQ-026 SHALL, with wp=1, reject as in REQ-013/014 any PROG or ERASE_SECTOR targeting sector 0, and any ERASE_ALL.
REQ-027 SHALL, without FLASH_WRITE_PROTECT_EN, have no wp port and no protection.

Structure
REQ-028 SHALL place op encodings, the state encoding and the ERASED_VALUE constant in shared package flash_pkg.
REQ-029 SHALL instantiate sub-module flash_mem: DEPTH x DATA_W array, combinational read port, single synchronous write port, no reset.

Verification
REQ-030 Bench SHALL cover: PROG addr=5 wdata=0xDEADBEEF onto an erased word -> busy high 4 cycles, then done for 1 cycle; a subsequent READ addr=5 -> rvalid for 1 cycle with rdata=0xDEADBEEF.
REQ-031 Bench SHALL cover: a second PROG to addr 5 -> error for 1 cycle, busy=0, and READ still returns 0xDEADBEEF.
REQ-032 Bench SHALL cover: ERASE_SECTOR addr=70 after programming words 64, 127 and 128 -> busy for 64 cycles; words 64 and 127 read 0, word 128 unchanged.
REQ-033 Bench SHALL cover: READ addr=1024 (DEPTH=1024) -> error pulse, no rvalid; ERASE_ALL -> busy for 1024 cycles, all words read 0.
REQ-034 Bench SHALL cover: rst asserted at busy cycle 10 of ERASE_SECTOR on sector 1 -> outputs reset asynchronously; words 64..73 are 0 and words 74..127 keep their prior values.
REQ-035 Bench SHALL cover, with FLASH_WRITE_PROTECT_EN and wp=1: PROG addr=3 -> error pulse and word unchanged; the same PROG with wp=0 -> accepted.
